if_fetch_stage: RTL and testbench

//  Instruction-fetch front end of the 5-stage pipelined core; drives the IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/if_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the core front end.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_INC           : sequential PC step (one 32-bit word)
//   fetch_entry_t    : {pc, instr} pair carried from fetch into decode
//   word_align()     : clears the two byte-offset bits of an address
package cpu_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, reset    : clock, synchronous active-high reset
//   flush         : empties the queue; wins over push/pop in the same cycle
//   push, push_data
//   pop, pop_data : pop_data is the current head (valid only when !empty)
//   count, empty  : occupancy
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch front end feeding the IF/ID register.
//   clk, reset                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc    : taken-branch redirect from EX/MEM
//   imem_req_valid/addr/ready      : in-order fetch requests to instruction memory
//   imem_rsp_valid/data            : in-order returned words (latency >= 1)
//   if_valid, if_pc, if_instr      : head of the fetch queue presented to decode
//   id_ready                       : decode accepts the presented instruction
// Optional feature (macro FETCH_PERF_EN): perf_fetched / perf_stall saturating counters.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  drop_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;

    logic              credit_ok;
    logic              req_fire;
    logic              rsp_accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_target;

    // Every slot is either buffered or in flight, so the queue can never overflow.
    assign credit_ok       = (32'(outstanding_q) + 32'(fifo_count)) < DEPTH;
    assign imem_req_valid  = ~reset & credit_ok & ~redirect_valid;
    assign imem_req_addr   = pc_q;
    assign req_fire        = imem_req_valid & imem_req_ready;

    // A stray response with nothing outstanding is ignored.
    assign rsp_accept      = imem_rsp_valid & (outstanding_q != '0);
    assign push            = ~reset & ~redirect_valid & rsp_accept & (drop_q == '0);
    assign pop             = ~reset & ~redirect_valid & if_valid & id_ready;
    assign redirect_target = word_align(redirect_pc);

    assign push_entry.pc    = rsp_pc_q;
    assign push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the wrong path.
            pc_q          <= redirect_target;
            rsp_pc_q      <= redirect_target;
            outstanding_q <= outstanding_q - CNT_W'(rsp_accept);
            drop_q        <= outstanding_q - CNT_W'(rsp_accept);
        end else begin
            if (req_fire) begin
                pc_q <= pc_q + PC_INC;
            end
            if (rsp_accept) begin
                if (drop_q != '0) begin
                    drop_q <= drop_q - CNT_W'(1);
                end else begin
                    rsp_pc_q <= rsp_pc_q + PC_INC;
                end
            end
            outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_accept);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && imem_rsp_valid) begin
            assert (outstanding_q != '0)
                else $error("if_fetch_stage: response with no outstanding request");
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign if_valid = ~fifo_empty;
    assign if_pc    = if_valid ? fifo_head.pc    : '0;
    assign if_instr = if_valid ? fifo_head.instr : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && perf_fetched_q != '1) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (if_valid && !id_ready && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage.
// Main DUT: RESET_PC=0, DEPTH=2, with a bench memory of selectable latency (1..3).
// Wrap DUT: RESET_PC=...FFFC, DEPTH=4, 1-cycle memory, decode always ready.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_if_valid;
    logic [63:0] w_if_pc;
    logic [31:0] w_if_instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] w_perf_fetched;
    logic [31:0] w_perf_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat = 1;
    int req_limit = 1000;
    int n_acc = 0;

    logic        pipe_v [3];
    logic [63:0] pipe_a [3];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    if_fetch_stage #(
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    if_fetch_stage #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC),
        .DEPTH    (4)
    ) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0),
        .imem_req_valid (w_req_valid),
        .imem_req_addr  (w_req_addr),
        .imem_req_ready (1'b1),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .if_valid       (w_if_valid),
        .if_pc          (w_if_pc),
        .if_instr       (w_if_instr),
        .id_ready       (1'b1)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (w_perf_fetched),
        .perf_stall     (w_perf_stall)
`endif
    );

    // Main memory: in-order pipeline, response visible lat cycles after acceptance.
    assign imem_req_ready = (n_acc < req_limit);
    assign imem_rsp_valid = pipe_v[lat-1];
    assign imem_rsp_data  = word(pipe_a[lat-1]);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= 64'h0;
            end
            n_acc <= 0;
        end else begin
            pipe_v[0] <= imem_req_valid & imem_req_ready;
            pipe_a[0] <= imem_req_addr;
            for (int i = 1; i < 3; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            if (imem_req_valid && imem_req_ready) begin
                n_acc <= n_acc + 1;
            end
        end
    end

    // Wrap memory: fixed 1-cycle latency, always ready.
    always @(posedge clk) begin
        w_rsp_valid <= !reset && w_req_valid;
        w_rsp_data  <= word(w_req_addr);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int l);
        @(negedge clk);
        reset          = 1'b1;
        lat            = l;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        req_limit      = 1000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Checks the next n instructions accepted by decode: consecutive PCs from first_pc.
    task automatic expect_pops(input string tag, input logic [63:0] first_pc, input int n);
        int          got = 0;
        int          cyc = 0;
        logic [63:0] exp = first_pc;
        while (got < n && cyc < 40) begin
            if (if_valid && id_ready) begin
                check_val({tag, "_pc"}, if_pc, exp);
                check_val({tag, "_instr"}, {32'h0, if_instr}, {32'h0, word(exp)});
                exp = exp + 64'd4;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        int          cyc;
        logic [63:0] exp;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b1;

        // Reset state, then first request right after release.
        repeat (2) @(negedge clk);
        check_val("rst_if_valid", {63'h0, if_valid}, 64'h0);
        check_val("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check_val("rst_if_pc", if_pc, 64'h0);
        check_val("rst_if_instr", {32'h0, if_instr}, 64'h0);
        reset = 1'b0;
        #1;
        check_val("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check_val("first_req_addr", imem_req_addr, 64'h0);

        // Streaming with 1-cycle memory.
        expect_pops("stream", 64'h0, 4);

        // Decode stall: queue fills, requests stop, head frozen.
        do_reset(1);
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("stall_pc_a", if_pc, 64'h0);
        repeat (2) @(negedge clk);
        check_val("stall_if_valid", {63'h0, if_valid}, 64'h1);
        check_val("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check_val("stall_pc_b", if_pc, 64'h0);
        id_ready = 1'b1;
        expect_pops("stall", 64'h0, 3);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset(3);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        #1;
        check_val("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        check_val("redir_if_valid", {63'h0, if_valid}, 64'h0);
        expect_pops("redir", 64'h100, 2);

        // Redirect in the same cycle as a pop and a response.
        do_reset(1);
        repeat (2) @(negedge clk);
        check_val("rpop_pre_valid", {63'h0, if_valid}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_val("rpop_flushed", {63'h0, if_valid}, 64'h0);
        expect_pops("rpop", 64'h200, 2);

        // PC wrap on the second instance: consecutive cycles, no gaps.
        do_reset(1);
        cyc = 0;
        while (!w_if_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        exp = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            check_val("wrap_valid", {63'h0, w_if_valid}, 64'h1);
            check_val("wrap_pc", w_if_pc, exp);
            check_val("wrap_instr", {32'h0, w_if_instr}, {32'h0, word(exp)});
            exp = exp + 64'd4;
            @(negedge clk);
        end

`ifdef FETCH_PERF_EN
        // Exactly 10 words fetched and 4 stalled cycles.
        do_reset(1);
        req_limit = 10;
        id_ready  = 1'b0;
        cyc = 0;
        while (!if_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("perf_pre_valid", {63'h0, if_valid}, 64'h1);
        repeat (4) @(negedge clk);
        id_ready = 1'b1;
        repeat (40) @(negedge clk);
        check_val("perf_fetched", {32'h0, perf_fetched}, 64'd10);
        check_val("perf_stall", {32'h0, perf_stall}, 64'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
